rip_axi_slave_mem: RTL

AXI4 responder (slave) memory that sits on the far end of the rip core's AXI master port and answers its read and write bursts from an internal word array. The board test harness and simulation benches use it in place of the PS/DDR path. Its flat port list matches the core wrapper's AXI signal names one-to-one. It has independent read and write engines, each with one outstanding transaction, and supports FIXED and INCR bursts up to 256 beats.

---
 rtl/rip_axi_pkg.sv | 33 +++
 rtl/rip_axi_addr_gen.sv | 38 +++
 rtl/rip_axi_slave_mem.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rip_axi_pkg.sv
// Shared AXI encodings and FSM state types for the rip AXI responder memory.
package rip_axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Largest AxSIZE encoding that fits the data bus.
    function automatic logic [2:0] AXI_SIZE_MAX_F(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/rip_axi_addr_gen.sv
// Per-channel beat address arithmetic: next address, backing-array word index
// and the per-beat SLVERR condition (bad burst, oversize beat, out of range).
module rip_axi_addr_gen
    import rip_axi_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_WORDS = 4096,
    parameter int                IDX_W     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic [IDX_W-1:0]  word_idx,
    output logic              err
);

    localparam int                SHIFT    = $clog2(DATA_W / 8);
    localparam logic [2:0]        SIZE_MAX = AXI_SIZE_MAX_F(DATA_W);
    localparam logic [ADDR_W-1:0] DEPTH    = ADDR_W'(MEM_WORDS);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word;
    logic              burst_ok;

    assign offset    = addr - BASE_ADDR;
    assign word      = offset >> SHIFT;
    assign word_idx  = word[IDX_W-1:0];
    assign burst_ok  = (burst == FIXED) || (burst == INCR);

    // WRAP and reserved bursts still step like INCR; they only flag an error.
    assign next_addr = (burst == FIXED) ? addr : addr + (ADDR_W'(1) << size);

    assign err = (addr < BASE_ADDR) || (word >= DEPTH) || (size > SIZE_MAX) || !burst_ok;

endmodule

// File: rtl/rip_axi_slave_mem.sv
// AXI4 responder backed by a byte-enabled word array; independent read and
// write engines, one outstanding burst each, FIXED/INCR up to 256 beats.
module rip_axi_slave_mem #(
    parameter int                        AXI_ID_WIDTH   = 4,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        MEM_WORDS      = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                        clk,
    input  logic                        sys_rst,
    input  logic [AXI_ID_WIDTH-1:0]     AWID,
    input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]                  AWLEN,
    input  logic [2:0]                  AWSIZE,
    input  logic [1:0]                  AWBURST,
    input  logic                        AWVALID,
    input  logic                        AWLOCK,
    input  logic [3:0]                  AWCACHE,
    input  logic [2:0]                  AWPROT,
    input  logic [3:0]                  AWQOS,
    input  logic [3:0]                  AWREGION,
    output logic                        AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [AXI_ID_WIDTH-1:0]     BID,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic [AXI_ID_WIDTH-1:0]     ARID,
    input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]                  ARLEN,
    input  logic [2:0]                  ARSIZE,
    input  logic [1:0]                  ARBURST,
    input  logic                        ARVALID,
    input  logic                        ARLOCK,
    input  logic [3:0]                  ARCACHE,
    input  logic [2:0]                  ARPROT,
    input  logic [3:0]                  ARQOS,
    input  logic [3:0]                  ARREGION,
    output logic                        ARREADY,
    output logic [AXI_ID_WIDTH-1:0]     RID,
    output logic [AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY
);

    import rip_axi_pkg::*;

    localparam int AW     = AXI_ADDR_WIDTH;
    localparam int DW     = AXI_DATA_WIDTH;
    localparam int IDW    = AXI_ID_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int IDX_W  = $clog2(MEM_WORDS);

    logic unused_sideband;
    assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION,
                               ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION};

    // Write engine state
    wr_state_t         wstate_q, wstate_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [IDW-1:0]    bid_q, bid_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [2:0]        wsize_q, wsize_d;
    logic [1:0]        wburst_q, wburst_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              berr_q, berr_d;

    // Read engine state
    rd_state_t         rstate_q, rstate_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic              rzero_q, rzero_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [IDW-1:0]    rid_q, rid_d;
    logic [AW-1:0]     rnext_q, rnext_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [1:0]        rburst_q, rburst_d;
    logic [7:0]        rcnt_q, rcnt_d;

    logic [AW-1:0]     w_next, r_next, r_gen_addr;
    logic [IDX_W-1:0]  w_idx, r_idx;
    logic              w_err, r_err;
    logic [2:0]        r_gen_size;
    logic [1:0]        r_gen_burst;
    logic              w_beat_last, w_beat_bad, w_fire;
    logic              mem_we, mem_re;
    logic [STRB_W-1:0] lane_we;

    logic [DW-1:0]     mem [MEM_WORDS];
    logic [DW-1:0]     mem_rd_q;

    rip_axi_addr_gen #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W), .BASE_ADDR(BASE_ADDR)
    ) u_wr_addr (
        .addr(waddr_q), .size(wsize_q), .burst(wburst_q),
        .next_addr(w_next), .word_idx(w_idx), .err(w_err)
    );

    rip_axi_addr_gen #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W), .BASE_ADDR(BASE_ADDR)
    ) u_rd_addr (
        .addr(r_gen_addr), .size(r_gen_size), .burst(r_gen_burst),
        .next_addr(r_next), .word_idx(r_idx), .err(r_err)
    );

    assign w_fire      = (wstate_q == W_DATA) && WVALID && wready_q;
    assign w_beat_last = (wcnt_q == 8'd0);
    assign w_beat_bad  = w_err || (WLAST != w_beat_last);
    assign mem_we      = w_fire && !w_err;

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane_we
        assign lane_we[gi] = mem_we && WSTRB[gi];
    end

    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        waddr_d   = waddr_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        berr_d    = berr_q;
        case (wstate_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    bid_d     = AWID;
                    waddr_d   = AWADDR;
                    wsize_d   = AWSIZE;
                    wburst_d  = AWBURST;
                    wcnt_d    = AWLEN;
                    berr_d    = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    if (w_beat_last) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = (berr_q || w_beat_bad) ? SLVERR : OKAY;
                        wstate_d = W_RESP;
                    end else begin
                        berr_d  = berr_q || w_beat_bad;
                        waddr_d = w_next;
                        wcnt_d  = wcnt_q - 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Beat 0 is addressed straight from AR; later beats from the precomputed next address.
    always_comb begin
        if (rstate_q == R_IDLE) begin
            r_gen_addr  = ARADDR;
            r_gen_size  = ARSIZE;
            r_gen_burst = ARBURST;
        end else begin
            r_gen_addr  = rnext_q;
            r_gen_size  = rsize_q;
            r_gen_burst = rburst_q;
        end
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rzero_d   = rzero_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        rnext_d   = rnext_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        mem_re    = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    mem_re    = 1'b1;
                    rid_d     = ARID;
                    rsize_d   = ARSIZE;
                    rburst_d  = ARBURST;
                    rcnt_d    = ARLEN;
                    rlast_d   = (ARLEN == 8'd0);
                    rnext_d   = r_next;
                    rzero_d   = r_err;
                    rresp_d   = r_err ? SLVERR : OKAY;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY && rvalid_q) begin
                    if (rcnt_q == 8'd0) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        rstate_d  = R_IDLE;
                    end else begin
                        mem_re  = 1'b1;
                        rcnt_d  = rcnt_q - 8'd1;
                        rlast_d = (rcnt_q == 8'd1);
                        rnext_d = r_next;
                        rzero_d = r_err;
                        rresp_d = r_err ? SLVERR : OKAY;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
            waddr_q   <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            berr_q    <= 1'b0;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rzero_q   <= 1'b1;
            rresp_q   <= '0;
            rid_q     <= '0;
            rnext_q   <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            waddr_q   <= waddr_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            berr_q    <= berr_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rzero_q   <= rzero_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            rnext_q   <= rnext_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Read-before-write: a same-cycle read of a word being written sees the old value.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (lane_we[b]) begin
                mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
        if (mem_re) begin
            mem_rd_q <= mem[r_idx];
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign BID     = bid_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    assign RID     = rid_q;
    assign RDATA   = rzero_q ? '0 : mem_rd_q;

endmodule
